tm1637_byte_tx: RTL and testbench
=================================

TM1637_BYTE_TX -- requirements
Module: tm1637_byte_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 256, meaning clocks per bus half-phase (minimum 2); at 12 MHz that is about 21 us.
REQ-002 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_in, input, 8, the byte to transmit, LSB first.
REQ-005 SHALL have port data_latch, input, 1, the byte-request strobe from the sequencer.
REQ-006 SHALL have port data_stop_bit, input, 1, where 1 means a stop condition follows this byte.
REQ-007 SHALL have port busy, output, 1, high while a byte is in flight.
REQ-008 SHALL have port tm_clk, output, 1, the TM1637 CLK line.
REQ-009 SHALL have port dio_oe, output, 1, where 1 pulls DIO low and 0 releases it (external pull-up).
REQ-010 SHALL have port dio_in, input, 1, the sampled DIO pad level.
REQ-011 SHALL have port ack_err, output, 1, meaning the last byte was not acknowledged.

Function
REQ-012 SHALL accept a byte only on a clock edge where data_latch=1, busy=0 and the block is armed; at that edge it latches data_in and data_stop_bit.
- The block is re-armed only after data_latch has been sampled low.
- data_latch is ignored while busy=1.
REQ-013 SHALL assert busy on the edge following acceptance and hold it until the final phase ends.
- busy is high for exactly N*CLK_DIV cycles, where N is the phase count of that byte.
REQ-014 SHALL track bus_open, which is 0 after reset and after a stop, and 1 after a byte sent with data_stop_bit=0.
REQ-015 SHALL run the state machine IDLE -> START (only if bus_open=0) -> BIT_LO/BIT_HI x8 -> ACK_LO -> ACK_HI -> STOP_LO -> STOP_HI -> STOP_REL -> IDLE when the stop bit is set, or -> PARK -> IDLE when it is clear. Each state lasts CLK_DIV cycles, except IDLE and PARK.
REQ-016 SHALL hold tm_clk=1 and dio_oe=1 during START.
REQ-017 SHALL, in BIT_LO, set tm_clk=0 and dio_oe=~bit on the phase's first cycle; in BIT_HI, set tm_clk=1 with DIO unchanged.
REQ-018 SHALL hold tm_clk=0 and dio_oe=0 in ACK_LO, and tm_clk=1 and dio_oe=0 in ACK_HI, sampling dio_in on the last ACK_HI cycle.
REQ-019 SHALL drive the stop phases as follows:
- STOP_LO: tm_clk=0, dio_oe=1.
- STOP_HI: tm_clk=1, dio_oe=1.
- STOP_REL: tm_clk=1, dio_oe=0.
REQ-020 SHALL, for a byte without stop, drive tm_clk=0 and dio_oe=1 in PARK, and hold those levels until the next accepted byte starts directly in BIT_LO.
REQ-021 SHALL use phase counts N=22 (bus closed, stop set), N=21 (bus open, stop set), N=19 (bus closed, no stop) and N=18 (bus open, no stop).
REQ-022 SHALL clear ack_err on acceptance.
REQ-023 SHALL allow acceptance on the very edge on which busy falls, provided the block is armed and data_latch=1; the resulting gap between bytes is zero cycles.

Reset
REQ-024 SHALL, while reset_n=0, immediately force the following, asynchronously and irrespective of state:
- busy=0, tm_clk=1, dio_oe=0, ack_err=0
- bus_open=0, armed=1, state=IDLE, phase counter=0.
REQ-025 SHALL discard any in-flight byte on reset without completing it; the bus is left released.

Configuration
REQ-026 SHALL, when TM1637_ACK_CHECK_EN is defined, set ack_err=1 if dio_in=1 at the ACK sample point; ack_err holds until the next acceptance or reset.
REQ-027 SHALL, when TM1637_ACK_CHECK_EN is undefined, still generate the ACK phases but tie ack_err to 0 and not sample dio_in.

Verification
REQ-028 SHALL cover: reset, CLK_DIV=4, latch 0x40 with stop=1 -> start, DIO bits 0,0,0,0,0,0,1,0 on rising tm_clk, stop, busy high 88 cycles, final tm_clk=1 and dio_oe=0.
REQ-029 SHALL cover: 0xC0 with stop=0, then 0x3F with stop=1 -> no second start, tm_clk low between the bytes, busy 76 then 84 cycles.
REQ-030 SHALL cover: data_latch held high across the end of a byte -> no second acceptance until data_latch goes low and then high again.
REQ-031 SHALL cover: with TM1637_ACK_CHECK_EN defined, dio_in=1 during ACK_HI -> ack_err=1 after the byte, cleared on the next acceptance; with the macro undefined, ack_err stays 0.
REQ-032 SHALL cover: reset_n pulsed low during bit 3 -> same-cycle tm_clk=1, dio_oe=0, busy=0; the next byte begins with a start.
REQ-033 SHALL cover: data_latch asserted mid-byte -> ignored, and the current byte completes unaltered.

Source files
------------

// File: rtl/tm1637_byte_tx.sv
// tm1637_byte_tx: sends one byte on the TM1637 two-wire bus (CLK + open-drain DIO).
// The byte goes out LSB first, after a START when the bus is closed. It is followed by
// an ACK clock and then either a STOP or a park with CLK low, so the next byte can
// continue the open transaction.
// Optional feature: define TM1637_ACK_CHECK_EN to latch a missing ACK into ack_err.
// dbg_state exposes the FSM state for debug and assertion binding.
module tm1637_byte_tx #(
  parameter int CLK_DIV = 256  // clocks per bus half-phase, minimum 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_latch,
  input  logic       data_stop_bit,
  output logic       busy,
  output logic       tm_clk,
  output logic       dio_oe,
  input  logic       dio_in,
  output logic       ack_err,
  output logic [3:0] dbg_state
);

  // Handshake: a byte is taken on an edge where data_latch=1 and the block is armed,
  // and either busy=0 or the edge is the one that ends the current byte. That last
  // case chains the next byte with no gap. Taking a byte disarms the block. The
  // block re-arms on any edge that samples data_latch=0. While busy, data_latch only
  // re-arms the block and never interrupts the byte in flight.

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_BIT_LO,
    S_BIT_HI,
    S_ACK_LO,
    S_ACK_HI,
    S_STOP_LO,
    S_STOP_HI,
    S_STOP_REL,
    S_PARK
  } state_t;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          armed_q, armed_d;
  logic          bus_open_q, bus_open_d;
  logic          busy_q, busy_d;
  logic          tm_clk_q, tm_clk_d;
  logic          dio_oe_q, dio_oe_d;

  logic phase_end;
  logic byte_end;
  logic bus_open_eff;
  logic accept;

  assign phase_end = (cnt_q == LAST);
  // The last cycle of a byte is the end of STOP_REL, or the end of ACK_HI when no stop follows.
  assign byte_end = phase_end &&
                    ((state_q == S_STOP_REL) || ((state_q == S_ACK_HI) && !stop_q));
  // A byte chained onto the final edge must see the bus state the finishing byte leaves behind.
  assign bus_open_eff = byte_end ? ~stop_q : bus_open_q;
  assign accept = armed_q && data_latch &&
                  ((state_q == S_IDLE) || (state_q == S_PARK) || byte_end);

  // Next-state logic: phase sequencing, line levels for the coming phase, and byte acceptance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    armed_d    = armed_q | ~data_latch;
    bus_open_d = bus_open_q;
    busy_d     = busy_q;
    tm_clk_d   = tm_clk_q;
    dio_oe_d   = dio_oe_q;

    if ((state_q != S_IDLE) && (state_q != S_PARK)) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: ;
      S_PARK: state_d = S_IDLE;
      S_START: begin
        if (phase_end) begin
          state_d  = S_BIT_LO;
          tm_clk_d = 1'b0;
          dio_oe_d = ~shreg_q[0];
        end
      end
      S_BIT_LO: begin
        if (phase_end) begin
          state_d  = S_BIT_HI;
          tm_clk_d = 1'b1;
        end
      end
      S_BIT_HI: begin
        if (phase_end) begin
          tm_clk_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d  = S_ACK_LO;
            dio_oe_d = 1'b0;
          end else begin
            state_d  = S_BIT_LO;
            dio_oe_d = ~shreg_q[1];
            shreg_d  = shreg_q >> 1;
            bit_d    = bit_q + 3'd1;
          end
        end
      end
      S_ACK_LO: begin
        if (phase_end) begin
          state_d  = S_ACK_HI;
          tm_clk_d = 1'b1;
        end
      end
      S_ACK_HI: begin
        if (phase_end) begin
          tm_clk_d = 1'b0;
          dio_oe_d = 1'b1;
          if (stop_q) begin
            state_d = S_STOP_LO;
          end else begin
            state_d    = S_PARK;
            busy_d     = 1'b0;
            bus_open_d = 1'b1;
          end
        end
      end
      S_STOP_LO: begin
        if (phase_end) begin
          state_d  = S_STOP_HI;
          tm_clk_d = 1'b1;
        end
      end
      S_STOP_HI: begin
        if (phase_end) begin
          state_d  = S_STOP_REL;
          dio_oe_d = 1'b0;
        end
      end
      S_STOP_REL: begin
        if (phase_end) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          bus_open_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      armed_d = 1'b0;
      shreg_d = data_in;
      stop_d  = data_stop_bit;
      bit_d   = 3'd0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      if (bus_open_eff) begin
        state_d  = S_BIT_LO;
        tm_clk_d = 1'b0;
        dio_oe_d = ~data_in[0];
      end else begin
        state_d  = S_START;
        tm_clk_d = 1'b1;
        dio_oe_d = 1'b1;
      end
    end
  end

  // State and output registers; reset releases the bus at once and drops any byte in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      armed_q    <= 1'b1;
      bus_open_q <= 1'b0;
      busy_q     <= 1'b0;
      tm_clk_q   <= 1'b1;
      dio_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      armed_q    <= armed_d;
      bus_open_q <= bus_open_d;
      busy_q     <= busy_d;
      tm_clk_q   <= tm_clk_d;
      dio_oe_q   <= dio_oe_d;
    end
  end

`ifdef TM1637_ACK_CHECK_EN
  logic ack_q;
  logic ack_sample;

  assign ack_sample = (state_q == S_ACK_HI) && phase_end;

  // ACK capture: the pad level on the last ACK_HI cycle. If a new byte is taken on
  // the same edge, the clear from that acceptance wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
    end else if (accept) begin
      ack_q <= 1'b0;
    end else if (ack_sample) begin
      ack_q <= dio_in;
    end
  end

  assign ack_err = ack_q;
`else
  logic ack_unused;

  assign ack_unused = dio_in;
  assign ack_err    = 1'b0;
`endif

  assign busy      = busy_q;
  assign tm_clk    = tm_clk_q;
  assign dio_oe    = dio_oe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tm1637_byte_tx.sv
// tb_tm1637_byte_tx: table-driven and randomized checks of tm1637_byte_tx at CLK_DIV=4.
// The expected bus waveform comes from a phase-list model of the TM1637 protocol.
module tb_tm1637_byte_tx;
  localparam int CD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_latch = 1'b0;
  logic       data_stop_bit = 1'b0;
  logic       busy;
  logic       tm_clk;
  logic       dio_oe;
  logic       dio_in;
  logic       ack_err;
  logic [3:0] dbg_state;
  logic       nack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic model_open = 1'b0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic       s;
    int         busy_cycles;
  } vec_t;

  vec_t tbl[6];

  tm1637_byte_tx #(.CLK_DIV(CD)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_latch(data_latch),
    .data_stop_bit(data_stop_bit),
    .busy(busy),
    .tm_clk(tm_clk),
    .dio_oe(dio_oe),
    .dio_in(dio_in),
    .ack_err(ack_err),
    .dbg_state(dbg_state)
  );

  // Pad model: the master pulls DIO low when dio_oe=1. Otherwise the device either
  // acks by pulling the line low (nack=0) or leaves it at the pull-up (nack=1).
  assign dio_in = dio_oe ? 1'b0 : nack;

  // Clock generation.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic push_phase(input logic tm, input logic oe);
    for (int k = 0; k < CD; k++) exp_q.push_back({1'b1, tm, oe});
  endtask

  // Protocol-level expectation as {busy, tm_clk, dio_oe} per clock.
  task automatic build_expect(input logic [7:0] d, input logic s);
    exp_q.delete();
    if (!model_open) push_phase(1'b1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      push_phase(1'b0, ~d[b]);
      push_phase(1'b1, ~d[b]);
    end
    push_phase(1'b0, 1'b0);
    push_phase(1'b1, 1'b0);
    if (s) begin
      push_phase(1'b0, 1'b1);
      push_phase(1'b1, 1'b1);
      push_phase(1'b1, 1'b0);
    end
  endtask

  // mode 0: normal, 1: keep data_latch high, 2: latch pulse mid-byte,
  // 3: raise latch with (nd, ns) on the last cycle to chain the next byte.
  // pre=1: the byte was already presented by the previous call.
  task automatic run_byte(input logic [7:0] d, input logic s, input int mode, input int exp_busy,
                          input logic pre, input logic [7:0] nd, input logic ns);
    int total;
    int busy_cnt;
    int nbits;
    logic prev_tm;
    logic [7:0] got;
    logic [2:0] e;
    logic exp_ack;
    if (!pre) begin
      data_in = d;
      data_stop_bit = s;
      data_latch = 1'b1;
    end
    build_expect(d, s);
    total = exp_q.size();
`ifdef TM1637_ACK_CHECK_EN
    exp_ack = nack;
`else
    exp_ack = 1'b0;
`endif
    @(posedge clock);
    busy_cnt = 0;
    nbits = 0;
    got = 8'h00;
    prev_tm = 1'b1;
    for (int i = 0; i < total; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      check("wave", {29'd0, busy, tm_clk, dio_oe}, {29'd0, e});
      if (i == 0) begin
        check("ack_clear", {31'd0, ack_err}, 32'd0);
        if (mode != 1) data_latch = 1'b0;
        data_in = 8'($urandom);
        data_stop_bit = 1'($urandom);
      end
      if (busy) busy_cnt++;
      if (!prev_tm && tm_clk) begin
        if (nbits < 8) got[nbits] = ~dio_oe;
        nbits++;
      end
      prev_tm = tm_clk;
      if (mode == 2 && i == total / 2) data_latch = 1'b1;
      if (mode == 2 && i == total / 2 + 3) data_latch = 1'b0;
      if (mode == 3 && i == total - 1) begin
        data_in = nd;
        data_stop_bit = ns;
        data_latch = 1'b1;
      end
    end
    check("busy_len", busy_cnt, exp_busy);
    check("bits", {24'd0, got}, {24'd0, d});
    if (mode != 3) begin
      @(negedge clock);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("final_lines", {30'd0, tm_clk, dio_oe}, s ? 32'd2 : 32'd1);
      check("ack_err", {31'd0, ack_err}, {31'd0, exp_ack});
    end
    model_open = ~s;
  endtask

  initial begin
    int n;
    logic [7:0] rd;
    logic rs;

    tbl[0] = '{8'h40, 1'b1, 88};
    tbl[1] = '{8'hC0, 1'b0, 76};
    tbl[2] = '{8'h3F, 1'b1, 84};
    tbl[3] = '{8'hA5, 1'b0, 76};
    tbl[4] = '{8'h5A, 1'b0, 72};
    tbl[5] = '{8'hFF, 1'b1, 84};

    // Asynchronous reset: outputs settle before any clock edge.
    #1 reset_n = 1'b0;
    #2 check("reset", {28'd0, busy, tm_clk, dio_oe, ack_err}, 32'h4);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle", {29'd0, busy, tm_clk, dio_oe}, 32'h2);

    for (int t = 0; t < 6; t++) begin
      run_byte(tbl[t].d, tbl[t].s, 0, tbl[t].busy_cycles, 1'b0, 8'h00, 1'b0);
    end

    // Back-to-back: the second byte is taken on the edge the first one ends.
    run_byte(8'h21, 1'b0, 3, 76, 1'b0, 8'h84, 1'b1);
    run_byte(8'h84, 1'b1, 0, 84, 1'b1, 8'h00, 1'b0);

    // data_latch held high across the end of a byte: no re-acceptance.
    run_byte(8'h12, 1'b1, 1, 88, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("no_reaccept", {31'd0, busy}, 32'd0);
    end
    data_latch = 1'b0;
    @(negedge clock);

    // data_latch pulse mid-byte is ignored.
    run_byte(8'h34, 1'b0, 2, 76, 1'b0, 8'h00, 1'b0);

    // Reset during bit 3 of a byte on an open bus.
    data_in = 8'h00;
    data_stop_bit = 1'b0;
    data_latch = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 6 * CD + 2; i++) begin
      @(negedge clock);
      if (i == 0) data_latch = 1'b0;
    end
    check("pre_reset", {29'd0, busy, tm_clk, dio_oe}, 32'h5);
    #2 reset_n = 1'b0;
    #1 check("mid_reset", {28'd0, busy, tm_clk, dio_oe, ack_err}, 32'h4);
    @(negedge clock);
    reset_n = 1'b1;
    model_open = 1'b0;
    @(negedge clock);
    check("post_reset", {29'd0, busy, tm_clk, dio_oe}, 32'h2);
    run_byte(8'h66, 1'b1, 0, 88, 1'b0, 8'h00, 1'b0);

    // Missing ACK, then a normal byte clears ack_err on acceptance.
    nack = 1'b1;
    run_byte(8'h0F, 1'b1, 0, 88, 1'b0, 8'h00, 1'b0);
    nack = 1'b0;
    run_byte(8'hF0, 1'b0, 0, 76, 1'b0, 8'h00, 1'b0);

    // Randomized bytes, stop flags, ACK behaviour and idle gaps.
    for (int r = 0; r < 12; r++) begin
      rd = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      nack = ($urandom_range(0, 3) == 0);
      n = (model_open ? 18 : 19) + (rs ? 3 : 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_byte(rd, rs, 0, n * CD, 1'b0, 8'h00, 1'b0);
    end
    nack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
